// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx: PS/2 frame receiver assembling 3-byte mouse packets.
// Frames are checked for stop/parity/sync errors; data outputs change only on good packets.
module ps2_mouse_packet_rx #(
  parameter bit CHECK_PARITY = 1'b1,
  parameter bit SYNC_ON_BIT3 = 1'b1
) (
  input  logic       Mouse_Clk,
  input  logic       reset,
  input  logic       Mouse_Data,
  output logic       pkt_valid,
  output logic [7:0] status_byte,
  output logic [8:0] x_move,
  output logic [8:0] y_move,
  output logic [2:0] buttons,
  output logic       frame_err,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic       pkt_valid_q, pkt_valid_d, frame_err_q, frame_err_d;
  logic [7:0] err_count_q, err_count_d, status_q, status_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic       frame_ok, sync_bad;
  // In STOP the line carries the stop bit, so it is judged combinationally here.
  assign frame_ok = Mouse_Data && (!CHECK_PARITY || (^{shift_q, par_q}));
  assign sync_bad = SYNC_ON_BIT3 && byte_idx_q == 2'd0 && !shift_q[3];
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_idx_d  = byte_idx_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    pkt_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err_count_d = err_count_q;
    status_d    = status_q;
    x_d         = x_q;
    y_d         = y_q;
    case (state_q)
      IDLE: begin
        state_d   = Mouse_Data ? IDLE : DATA;
        bit_cnt_d = 3'd0;
      end
      DATA: begin
        shift_d   = {Mouse_Data, shift_q[7:1]};
        bit_cnt_d = (bit_cnt_q == 3'd7) ? 3'd0 : bit_cnt_q + 3'd1;
        state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
      end
      PARITY: begin
        par_d   = Mouse_Data;
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        if (!frame_ok || sync_bad) begin
          frame_err_d = 1'b1;
          err_count_d = err_count_q + {7'd0, err_count_q != 8'hFF};
          byte_idx_d  = 2'd0;
        end else if (byte_idx_q == 2'd2) begin
          pkt_valid_d = 1'b1;
          status_d    = hold0_q;
          x_d         = {hold0_q[4], hold1_q};
          y_d         = {hold0_q[5], shift_q};
          byte_idx_d  = 2'd0;
        end else begin
          hold0_d    = (byte_idx_q == 2'd0) ? shift_q : hold0_q;
          hold1_d    = (byte_idx_q == 2'd1) ? shift_q : hold1_q;
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(negedge Mouse_Clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      byte_idx_q  <= 2'd0;
      hold0_q     <= 8'd0;
      hold1_q     <= 8'd0;
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= 8'd0;
      status_q    <= 8'd0;
      x_q         <= 9'd0;
      y_q         <= 9'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      byte_idx_q  <= byte_idx_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      pkt_valid_q <= pkt_valid_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
      status_q    <= status_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end
  assign pkt_valid   = pkt_valid_q;
  assign frame_err   = frame_err_q;
  assign err_count   = err_count_q;
  assign status_byte = status_q;
  assign x_move      = x_q;
  assign y_move      = y_q;
  assign buttons     = status_q[2:0];
endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// tb_ps2_mouse_packet_rx: drives PS/2 frames into a parity-checking and a parity-ignoring
// receiver and compares both against a packet-level reference model.
module tb_ps2_mouse_packet_rx;
  logic Mouse_Clk, reset, Mouse_Data;
  logic [1:0] pv, fe;
  logic [1:0][7:0] st, ec;
  logic [1:0][8:0] xm, ym;
  logic [1:0][2:0] bt;
  int checks = 0, failures = 0;

  ps2_mouse_packet_rx #(.CHECK_PARITY(1'b1), .SYNC_ON_BIT3(1'b1)) dut_a (
    .Mouse_Clk(Mouse_Clk), .reset(reset), .Mouse_Data(Mouse_Data),
    .pkt_valid(pv[0]), .status_byte(st[0]), .x_move(xm[0]), .y_move(ym[0]),
    .buttons(bt[0]), .frame_err(fe[0]), .err_count(ec[0]));
  ps2_mouse_packet_rx #(.CHECK_PARITY(1'b0), .SYNC_ON_BIT3(1'b1)) dut_b (
    .Mouse_Clk(Mouse_Clk), .reset(reset), .Mouse_Data(Mouse_Data),
    .pkt_valid(pv[1]), .status_byte(st[1]), .x_move(xm[1]), .y_move(ym[1]),
    .buttons(bt[1]), .frame_err(fe[1]), .err_count(ec[1]));

  initial Mouse_Clk = 1'b1;
  always #10 Mouse_Clk = ~Mouse_Clk;

  // Packet-level model: index 0 checks parity, index 1 ignores it.
  int         cnt[2];
  logic [7:0] pb[2][2];
  logic       e_v[2], e_e[2];
  logic [7:0] e_ec[2], e_st[2];
  logic [8:0] e_x[2], e_y[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0; e_v[m] = 0; e_e[m] = 0; e_ec[m] = 0; e_st[m] = 0; e_x[m] = 0; e_y[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input logic [7:0] d, input bit p_ok, input bit s);
    bit good;
    good = s && (m == 1 || p_ok);
    e_v[m] = 0;
    e_e[m] = 0;
    if (!good || (cnt[m] == 0 && !d[3])) begin
      e_e[m] = 1;
      if (e_ec[m] < 8'd255) e_ec[m] = e_ec[m] + 8'd1;
      cnt[m] = 0;
    end else if (cnt[m] == 2) begin
      e_v[m] = 1;
      e_st[m] = pb[m][0];
      e_x[m] = {pb[m][0][4], pb[m][1]};
      e_y[m] = {pb[m][0][5], d};
      cnt[m] = 0;
    end else begin
      pb[m][cnt[m]] = d;
      cnt[m] = cnt[m] + 1;
    end
  endtask

  task automatic chk(input string n, input int m, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", n, m, a, e, $time);
    end
  endtask

  task automatic check_all(input string n);
    for (int m = 0; m < 2; m++) begin
      chk({n, ".pkt_valid"}, m, 32'(pv[m]), 32'(e_v[m]));
      chk({n, ".frame_err"}, m, 32'(fe[m]), 32'(e_e[m]));
      chk({n, ".err_count"}, m, 32'(ec[m]), 32'(e_ec[m]));
      chk({n, ".status"}, m, 32'(st[m]), 32'(e_st[m]));
      chk({n, ".x_move"}, m, 32'(xm[m]), 32'(e_x[m]));
      chk({n, ".y_move"}, m, 32'(ym[m]), 32'(e_y[m]));
      chk({n, ".buttons"}, m, 32'(bt[m]), 32'(e_st[m][2:0]));
    end
  endtask

  task automatic bit_out(input logic v);
    @(posedge Mouse_Clk);
    Mouse_Data = v;
    @(negedge Mouse_Clk);
  endtask

  // Ends 1 time unit after the stop-bit edge with the model updated and checked.
  task automatic send_frame(input logic [7:0] d, input bit p_ok, input bit s);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(p_ok ? ~^d : ^d);
    bit_out(s);
    for (int m = 0; m < 2; m++) model_step(m, d, p_ok, s);
    #1;
    check_all("frame");
  endtask

  task automatic idle_check();
    bit_out(1'b1);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("pulse_clear.pkt_valid", m, 32'(pv[m]), 32'(0));
      chk("pulse_clear.frame_err", m, 32'(fe[m]), 32'(0));
      e_v[m] = 0; e_e[m] = 0;
    end
  endtask

  typedef struct {
    logic [7:0] d; bit p_ok; bit s;
    bit ev; bit ee; logic [7:0] ecnt; logic [7:0] st; logic [8:0] x; logic [8:0] y;
  } vec_t;
  vec_t tbl[15];

  initial begin
    int nb_err;
    logic [7:0] d, b_cnt;
    tbl[0]  = '{8'h29, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 9'h000, 9'h000};
    tbl[1]  = '{8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 9'h000, 9'h000};
    tbl[2]  = '{8'hFB, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'h29, 9'h005, 9'h1FB};
    tbl[3]  = '{8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h29, 9'h005, 9'h1FB};
    tbl[4]  = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'h29, 9'h005, 9'h1FB};
    tbl[5]  = '{8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'h29, 9'h005, 9'h1FB};
    tbl[6]  = '{8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'h29, 9'h005, 9'h1FB};
    tbl[7]  = '{8'h20, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'h08, 9'h010, 9'h020};
    tbl[8]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'h08, 9'h010, 9'h020};
    tbl[9]  = '{8'h18, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'h08, 9'h010, 9'h020};
    tbl[10] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'h08, 9'h010, 9'h020};
    tbl[11] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'h18, 9'h1FF, 9'h001};
    tbl[12] = '{8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'h18, 9'h1FF, 9'h001};
    tbl[13] = '{8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'h18, 9'h1FF, 9'h001};
    tbl[14] = '{8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 8'h18, 9'h1FF, 9'h001};
    model_reset();
    reset = 1'b1;
    Mouse_Data = 1'b1;
    repeat (3) @(negedge Mouse_Clk);
    #1;
    check_all("reset_state");
    @(posedge Mouse_Clk);
    reset = 1'b0;
    // Directed packet vectors with hand-computed expectations for the parity-checking receiver.
    for (int i = 0; i < 15; i++) begin
      send_frame(tbl[i].d, tbl[i].p_ok, tbl[i].s);
      chk("tbl.pkt_valid", i, 32'(pv[0]), 32'(tbl[i].ev));
      chk("tbl.frame_err", i, 32'(fe[0]), 32'(tbl[i].ee));
      chk("tbl.err_count", i, 32'(ec[0]), 32'(tbl[i].ecnt));
      chk("tbl.status", i, 32'(st[0]), 32'(tbl[i].st));
      chk("tbl.x_move", i, 32'(xm[0]), 32'(tbl[i].x));
      chk("tbl.y_move", i, 32'(ym[0]), 32'(tbl[i].y));
      chk("tbl.buttons", i, 32'(bt[0]), 32'(tbl[i].st[2:0]));
      idle_check();
    end
    // Reset during byte 2, after its start bit and 5 data bits.
    send_frame(8'h08, 1'b1, 1'b1);
    idle_check();
    d = 8'h10;
    bit_out(1'b0);
    for (int i = 0; i < 5; i++) bit_out(d[i]);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    repeat (4) begin
      @(posedge Mouse_Clk);
      Mouse_Data = 1'($urandom_range(0, 1));
      @(negedge Mouse_Clk);
      #1;
      check_all("reset_held");
    end
    @(posedge Mouse_Clk);
    Mouse_Data = 1'b1;
    reset = 1'b0;
    send_frame(8'h29, 1'b1, 1'b1);
    idle_check();
    send_frame(8'h05, 1'b1, 1'b1);
    idle_check();
    send_frame(8'hFB, 1'b1, 1'b1);
    chk("after_reset.pkt_valid", 0, 32'(pv[0]), 32'(1));
    chk("after_reset.x_move", 0, 32'(xm[0]), 32'h005);
    chk("after_reset.y_move", 0, 32'(ym[0]), 32'h1FB);
    chk("after_reset.err_count", 0, 32'(ec[0]), 32'(0));
    idle_check();
    // Random frames with occasional parity/stop faults and idle gaps.
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) d[3] = 1'b1;
      send_frame(d, $urandom_range(0, 9) != 0, $urandom_range(0, 19) != 0);
      idle_check();
      repeat ($urandom_range(0, 2)) bit_out(1'b1);
    end
    // Parity-error flood: saturates the checking receiver, invisible to the other.
    nb_err = 0;
    b_cnt = e_ec[1];
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom) | 8'h08;
      send_frame(d, 1'b0, 1'b1);
      if (fe[1] !== 1'b0) nb_err++;
      idle_check();
    end
    chk("sat.err_count", 0, 32'(ec[0]), 32'hFF);
    chk("noparity.err_count", 1, 32'(ec[1]), 32'(b_cnt));
    chk("noparity.frame_err_pulses", 1, 32'(nb_err), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
